// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
package mul_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

   localparam logic [1:0] FLAGW_NONE = 2'b00;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

endpackage

// File: rtl/mul_seq_datapath.sv
// Shift-add datapath: multiplicand/multiplier/accumulator/count registers and adder.
// MUL_SEQ_EARLY_TERM_EN: finish as soon as the shifted multiplier has no set bits left.
module mul_seq_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] acc_next,
   output logic             final_step
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Value the accumulator takes if the current cycle is a RUN step.
   assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef MUL_SEQ_EARLY_TERM_EN
   assign final_step = (count_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
   assign final_step = (count_q == CNT_W'(WIDTH - 1));
`endif

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      if (load) begin
         mcand_d  = src_a;
         mplier_d = src_b;
         acc_d    = '0;
         count_d  = '0;
      end else if (step) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_next;
         count_d  = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL sequencer: IDLE/RUN/DONE control around mul_seq_datapath, with
// registered ALU-style Result/NZCV/FlagW. Early exit is selected by MUL_SEQ_EARLY_TERM_EN.
module mul_sequencer
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             S,
   input  logic             flush,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       Flags,
   output logic [1:0]       FlagW
);

   mul_state_t       state_q, state_d;
   logic             s_q, s_d;
   logic             busy_q, done_q;
   logic [1:0]       flagw_q, flagw_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic             load, step;
   logic [WIDTH-1:0] acc_next;
   logic             final_step;

   mul_seq_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .step       (step),
      .src_a      (SrcA),
      .src_b      (SrcB),
      .acc_next   (acc_next),
      .final_step (final_step)
   );

   // flush overrides everything, including a start seen in IDLE or DONE.
   assign load = !flush && start && (state_q == IDLE || state_q == DONE);
   assign step = !flush && (state_q == RUN);

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      result_d = result_q;
      flags_d  = flags_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
               if (final_step) begin
                  state_d         = DONE;
                  result_d        = acc_next;
                  flags_d         = '0;
                  flags_d[N_IDX]  = acc_next[WIDTH-1];
                  flags_d[Z_IDX]  = (acc_next == '0);
                  flags_d[C_IDX]  = 1'b0;
                  flags_d[V_IDX]  = 1'b0;
               end
            end
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
         endcase
      end
      if (load) s_d = S;
      flagw_d = (state_d == DONE) ? {s_d, 1'b0} : FLAGW_NONE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         s_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         flagw_q  <= FLAGW_NONE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         busy_q   <= (state_d == RUN);
         done_q   <= (state_d == DONE);
         flagw_q  <= flagw_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Result = result_q;
   assign Flags  = flags_q;
   assign FlagW  = flagw_q;

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle shift-add sequencer that executes MUL (low WIDTH bits of the product) for the pipelined ARM core. It sits beside the execute-stage ALU and is launched by the controller when a multiply is decoded. It holds Busy so the hazard unit stalls the pipeline, then presents Result, NZCV and FlagW in the same encoding the ALU decoder uses: FlagW[1] covers N/Z and FlagW[0] covers C/V.

Parameters:
WIDTH, 32, operand and result width in bits (>= 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  active-low synchronous reset (0 = reset, sampled on clk rising edge)
start  input  1  launch request; SrcA/SrcB/S are sampled in the same cycle
SrcA  input  WIDTH  multiplicand
SrcB  input  WIDTH  multiplier
S  input  1  set-flags bit of the instruction
flush  input  1  abort any operation in progress (branch/exception flush)
Busy  output  1  high while state == RUN
Done  output  1  one-cycle pulse; Result/Flags/FlagW valid this cycle
Result  output  WIDTH  product [WIDTH-1:0], registered
Flags  output  4  {N,Z,C,V}; C = V = 0
FlagW  output  2  {S_q, 1'b0} during Done, 2'b00 otherwise

Behaviour:
- Reset (reset == 0 at the clk edge), from any state including mid-operation:
  - state -> IDLE
  - Busy, Done, FlagW, Flags = 0; Result = 0; internal mcand/mplier/acc/count/S_q = 0
- FSM states IDLE, RUN, DONE. Priority at each edge: reset > flush > normal transition.
- IDLE:
  - start = 1 -> RUN; load mcand = SrcA, mplier = SrcB, acc = 0, count = 0, S_q = S.
  - start = 0 -> stay in IDLE.
- RUN, one step per cycle:
  - if mplier[0], acc <= acc + mcand (modulo 2^WIDTH)
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1
  - after the step with count == WIDTH-1 -> DONE
  - start is ignored in RUN; operands are not re-sampled.
- DONE, exactly one cycle:
  - Done = 1; Result = acc (registered on RUN->DONE); Flags = {Result[WIDTH-1], Result == 0, 0, 0}; FlagW = {S_q, 0}.
  - start = 1 in DONE -> RUN directly with fresh operands (back-to-back, no IDLE bubble).
  - Otherwise -> IDLE.
- Latency: start at cycle 0 -> Busy high for cycles 1..WIDTH -> Done at cycle WIDTH+1.
- Result and Flags hold their last values until the next DONE. FlagW and Done are nonzero only in DONE.
- flush = 1 in RUN or DONE -> IDLE next edge:
  - no Done pulse; FlagW = 0 in the following cycle
  - Result is not updated by the aborted operation
  - flush and start together in IDLE: flush wins and start is dropped.
- count width is clog2(WIDTH)+1. No overflow or carry reporting; the upper product bits are discarded.

Optional Feature:
- Macro: MUL_SEQ_EARLY_TERM_EN.
- Defined: RUN also exits to DONE after any step whose shifted mplier (mplier >> 1) equals 0.
  - SrcB = 0 or 1 -> Done at cycle 2.
  - SrcB = 5 -> Done at cycle 4.
  - The Result value is unchanged by early exit.
- Undefined: fixed WIDTH-step latency regardless of operands.

Decomposition:
- Package mul_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t
  - localparam FLAGW_NONE = 2'b00
  - flag bit index constants N_IDX = 3, Z_IDX = 2, C_IDX = 1, V_IDX = 0
- One sub-module, mul_seq_datapath: the mcand/mplier/acc/count registers and adder, driven by load/step enables from the FSM in mul_sequencer.

Test Plan:
- Reset held 3 cycles, then SrcA = 7, SrcB = 6, S = 1, start pulse at cycle 0 -> Busy cycles 1..32; Done at cycle 33 with Result = 42, Flags = 4'b0000, FlagW = 2'b10.
- SrcA = 0xFFFFFFFF, SrcB = 2, S = 0 -> Result = 0xFFFFFFFE, Flags = 4'b1000, FlagW = 2'b00 at Done.
- start with SrcA = 3, SrcB = 3, then start with SrcA = 9, SrcB = 9 at cycle 10 (during RUN) -> second start ignored; Result = 9 at cycle 33. start held in the Done cycle with SrcA = 0, SrcB = 5 -> Busy next cycle, Done at cycle 66, Result = 0, Flags = 4'b0100.
- flush at cycle 10 of an operation -> IDLE at cycle 11; no Done pulse; Result keeps its previous value.
- reset = 0 asserted at cycle 20 of an operation -> all outputs 0 next cycle; a new start completes normally.
- With MUL_SEQ_EARLY_TERM_EN: SrcA = 4, SrcB = 5 -> Done at cycle 4, Result = 20. SrcB = 0 -> Done at cycle 2, Result = 0, Z = 1.
